// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: shares one memory port between fetch (imem) and load/store (dmem).
// Registered grant FSM with data priority and a per-access hang timeout.
module elbeth_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_en,
  output logic [DATA_W-1:0] imem_rdata,
  output logic              imem_ready,
  output logic              imem_error,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_wdata,
  input  logic [3:0]        dmem_wr,
  input  logic              dmem_en,
  output logic [DATA_W-1:0] dmem_rdata,
  output logic              dmem_ready,
  output logic              dmem_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wr,
  output logic              mem_en,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              mem_error
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    IMEM_BUSY = 2'd1,
    DMEM_BUSY = 2'd2
  } state_t;

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wr_q, mem_wr_d;
  logic              mem_en_q, mem_en_d;
  logic [7:0]        cnt_q, cnt_d;

  logic to_hit;
  logic i_own;
  logic d_own;

  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_CNT) && !mem_ready;
  assign i_own  = (state_q == IMEM_BUSY);
  assign d_own  = (state_q == DMEM_BUSY);

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign mem_en    = mem_en_q;

  // Grant, freeze and release of the shared port
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = mem_wr_q;
    mem_en_d    = mem_en_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (dmem_en) begin
          mem_addr_d  = dmem_addr;
          mem_wdata_d = dmem_wdata;
          mem_wr_d    = dmem_wr;
          mem_en_d    = 1'b1;
          cnt_d       = '0;
          state_d     = DMEM_BUSY;
        end else if (imem_en) begin
          mem_addr_d  = imem_addr;
          mem_wdata_d = '0;
          mem_wr_d    = '0;
          mem_en_d    = 1'b1;
          cnt_d       = '0;
          state_d     = IMEM_BUSY;
        end else begin
          mem_en_d = 1'b0;
        end
      end
      IMEM_BUSY, DMEM_BUSY: begin
        if (mem_ready || to_hit) begin
          mem_en_d = 1'b0;
          state_d  = IDLE;
        end else if (cnt_q != 8'hFF) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        mem_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // State and shared-port registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= '0;
      mem_en_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      mem_en_q    <= mem_en_d;
      cnt_q       <= cnt_d;
    end
  end

  // Owner-qualified completion returned in the same cycle as mem_ready
  always_comb begin
    imem_ready = i_own & (mem_ready | to_hit);
    dmem_ready = d_own & (mem_ready | to_hit);
    imem_error = i_own & (mem_ready ? mem_error : to_hit);
    dmem_error = d_own & (mem_ready ? mem_error : to_hit);
    imem_rdata = (i_own && mem_ready) ? mem_rdata : '0;
    dmem_rdata = (d_own && mem_ready) ? mem_rdata : '0;
  end

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// tb_elbeth_mem_arbiter: scoreboard bench for the shared memory arbiter.
// Memory model answers after a programmable number of busy cycles.
module tb_elbeth_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic        imem_en, imem_ready, imem_error;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wr;
  logic        dmem_en, dmem_ready, dmem_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wr;
  logic        mem_en, mem_ready, mem_error;

  always #5 clk = ~clk;

  elbeth_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_addr(imem_addr),
    .imem_en(imem_en),
    .imem_rdata(imem_rdata),
    .imem_ready(imem_ready),
    .imem_error(imem_error),
    .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata),
    .dmem_wr(dmem_wr),
    .dmem_en(dmem_en),
    .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready),
    .dmem_error(dmem_error),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wr(mem_wr),
    .mem_en(mem_en),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_error(mem_error)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [32:0] iq[$];
  logic [32:0] dq[$];

  int   lat = 1;
  int   mcnt = 0;
  bit   hang = 0;
  bit   err_v = 0;
  bit   force_rdy = 0;
  logic mdl_rdy = 1'b0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [32:0] exp_of(input logic [31:0] a);
    if (hang) return {1'b1, 32'h0};
    return {err_v, word(a)};
  endfunction

  assign mem_ready = mdl_rdy | force_rdy;
  assign mem_rdata = force_rdy ? 32'h77 : (mdl_rdy ? word(mem_addr) : 32'h0);
  assign mem_error = mem_ready & err_v;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // memory model: ready on the lat-th busy cycle unless hung
  initial forever begin
    @(posedge clk);
    #1;
    if (!mem_en) begin
      mcnt = 0;
      mdl_rdy = 1'b0;
    end else begin
      mdl_rdy = !hang && (mcnt == lat - 1);
      mcnt++;
    end
  end

  // scoreboard: every ready pulse pops one expected response
  initial forever begin
    logic [32:0] e;
    @(negedge clk);
    if (imem_ready) begin
      if (iq.size() == 0) chk("imem_spurious", 1, 0);
      else begin
        e = iq.pop_front();
        chk("imem_rdata", imem_rdata, e[31:0]);
        chk("imem_error", 32'(imem_error), 32'(e[32]));
      end
    end
    if (dmem_ready) begin
      if (dq.size() == 0) chk("dmem_spurious", 1, 0);
      else begin
        e = dq.pop_front();
        chk("dmem_rdata", dmem_rdata, e[31:0]);
        chk("dmem_error", 32'(dmem_error), 32'(e[32]));
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [32:0] e);
    bit ok = 0;
    iq.push_back(e);
    imem_addr = a;
    imem_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (imem_ready) begin
        ok = 1;
        break;
      end
    end
    chk("fetch_done", 32'(ok), 1);
    @(posedge clk);
    #1;
    imem_en = 1'b0;
  endtask

  task automatic dreq(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] wr, input logic [32:0] e);
    bit ok = 0;
    dq.push_back(e);
    dmem_addr = a;
    dmem_wdata = wd;
    dmem_wr = wr;
    dmem_en = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dmem_ready) begin
        ok = 1;
        break;
      end
    end
    chk("dreq_done", 32'(ok), 1);
    @(posedge clk);
    #1;
    dmem_en = 1'b0;
    dmem_wr = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    imem_addr = '0;
    imem_en = 1'b0;
    dmem_addr = '0;
    dmem_wdata = '0;
    dmem_wr = '0;
    dmem_en = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 32'(mem_en), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wr", 32'(mem_wr), 0);
    chk("rst_irdy", 32'(imem_ready), 0);
    chk("rst_drdy", 32'(dmem_ready), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // fetch with two busy cycles
    lat = 2;
    @(posedge clk);
    #1;
    fork
      fetch(32'h100, exp_of(32'h100));
      begin
        @(negedge clk);
        chk("t1_lat", 32'(mem_en), 0);
        @(negedge clk);
        chk("t1_en", 32'(mem_en), 1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_wr", 32'(mem_wr), 0);
        chk("t1_early", 32'(imem_ready), 0);
      end
    join

    // simultaneous requests: data first, one idle cycle, then fetch
    lat = 1;
    @(posedge clk);
    #1;
    fork
      fetch(32'h400, exp_of(32'h400));
      dreq(32'h2000, 32'hDEADBEEF, 4'hF, exp_of(32'h2000));
      begin
        @(negedge clk);
        chk("t2_lat", 32'(mem_en), 0);
        @(negedge clk);
        chk("t2_daddr", mem_addr, 32'h2000);
        chk("t2_dwr", 32'(mem_wr), 32'hF);
        chk("t2_dwdata", mem_wdata, 32'hDEADBEEF);
        chk("t2_drdy", 32'(dmem_ready), 1);
        chk("t2_irdy", 32'(imem_ready), 0);
        @(negedge clk);
        chk("t2_idle", 32'(mem_en), 0);
        @(negedge clk);
        chk("t2_ien", 32'(mem_en), 1);
        chk("t2_iaddr", mem_addr, 32'h400);
        chk("t2_iwr", 32'(mem_wr), 0);
        chk("t2_iwdata", mem_wdata, 0);
      end
    join

    // hung memory: timeout on 5th busy cycle, late ready ignored
    hang = 1;
    @(posedge clk);
    #1;
    fork
      fetch(32'h500, exp_of(32'h500));
      begin
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("t3_early", 32'(imem_ready), 0);
        @(negedge clk);
        chk("t3_rdy", 32'(imem_ready), 1);
        chk("t3_err", 32'(imem_error), 1);
        @(negedge clk);
        chk("t3_en", 32'(mem_en), 0);
        @(posedge clk);
        #1;
        force_rdy = 1;
        @(negedge clk);
        chk("t3_late_rdy", 32'(imem_ready), 0);
        chk("t3_late_rdata", imem_rdata, 0);
        chk("t3_late_en", 32'(mem_en), 0);
        @(posedge clk);
        #1;
        force_rdy = 0;
      end
    join
    hang = 0;

    // load with bus error
    err_v = 1;
    lat = 1;
    @(posedge clk);
    #1;
    fork
      dreq(32'h3000, 32'h0, 4'h0, exp_of(32'h3000));
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t4_derr", 32'(dmem_error), 1);
        chk("t4_irdy", 32'(imem_ready), 0);
      end
    join
    err_v = 0;

    // requester address changes mid-access
    lat = 3;
    @(posedge clk);
    #1;
    fork
      dreq(32'h3000, 32'h0, 4'h0, exp_of(32'h3000));
      begin
        @(negedge clk);
        @(negedge clk);
        chk("t6_addr1", mem_addr, 32'h3000);
        @(posedge clk);
        #1;
        dmem_addr = 32'h4000;
        @(negedge clk);
        chk("t6_addr2", mem_addr, 32'h3000);
        @(negedge clk);
        chk("t6_addr3", mem_addr, 32'h3000);
        chk("t6_rdy", 32'(dmem_ready), 1);
      end
    join

    // reset in the middle of a data access
    lat = 3;
    @(posedge clk);
    #1;
    dmem_addr = 32'h6000;
    dmem_wdata = 32'h55;
    dmem_wr = 4'h3;
    dmem_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_en", 32'(mem_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async", 32'(mem_en), 0);
    chk("t5_drdy", 32'(dmem_ready), 0);
    dmem_en = 1'b0;
    dmem_wr = 4'h0;
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_en2", 32'(mem_en), 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_wdata", mem_wdata, 0);
    chk("t5_wr", 32'(mem_wr), 0);

    // back-to-back mix
    for (int i = 0; i < 8; i++) begin
      lat = 1 + (i % 3);
      @(posedge clk);
      #1;
      if (i % 2 == 0)
        fetch(32'h1000 + 32'(i * 4), exp_of(32'h1000 + 32'(i * 4)));
      else
        dreq(32'h8000 + 32'(i * 16), 32'(i), 4'(i),
             exp_of(32'h8000 + 32'(i * 16)));
    end

    repeat (3) @(negedge clk);
    chk("iq_empty", 32'(iq.size()), 0);
    chk("dq_empty", 32'(dq.size()), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
